// File: rtl/hazard_unit_if.sv
// Hazard controller bus: pipeline-side hazard sources in, stall/flush controls and perf counters out.
interface hazard_unit_if;
  logic [4:0]  ID_Rs;
  logic [4:0]  ID_Rt;
  logic        ID_UsesRs;
  logic        ID_UsesRt;
  logic        IDEX_MemRead;
  logic [4:0]  IDEX_WriteReg;
  logic        IDEX_MulDiv;
  logic        BranchTaken;
  logic        PCWrite;
  logic        IFIDWrite;
  logic        IFIDFlush;
  logic        IDEXWrite;
  logic        IDEXFlush;
  logic        EXMEMFlush;
  logic [31:0] StallCycles;
  logic [31:0] FlushCount;

  modport master (
    output ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, IDEX_MemRead, IDEX_WriteReg,
           IDEX_MulDiv, BranchTaken,
    input  PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush, EXMEMFlush,
           StallCycles, FlushCount
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, IDEX_MemRead, IDEX_WriteReg,
           IDEX_MulDiv, BranchTaken,
    output PCWrite, IFIDWrite, IFIDFlush, IDEXWrite, IDEXFlush, EXMEMFlush,
           StallCycles, FlushCount
  );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use stall, EX branch flush, multi-cycle mul/div occupancy.
// Controls are combinational (zero-cycle response); only FSM state and perf counters are registered.
module hazard_unit #(
  parameter int unsigned MULDIV_CYCLES = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  hazard_unit_if.slave hz
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned PERF_W  = 32;
  localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MULDIV_CYCLES - 2);

  typedef enum logic [0:0] {RUN, MD_WAIT} state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    md_cnt, md_cnt_n;
  logic                md_done, md_done_n;
  logic [PERF_W-1:0]   stall_cnt, flush_cnt;
  logic                load_use;
  logic                branch_ev;

  assign load_use = hz.IDEX_MemRead && (hz.IDEX_WriteReg != 5'd0) &&
                    ((hz.ID_UsesRs && (hz.IDEX_WriteReg == hz.ID_Rs)) ||
                     (hz.ID_UsesRt && (hz.IDEX_WriteReg == hz.ID_Rt)));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= RUN;
      md_cnt  <= '0;
      md_done <= 1'b0;
    end else begin
      state   <= state_n;
      md_cnt  <= md_cnt_n;
      md_done <= md_done_n;
    end
  end

  // Next state and Mealy controls; md_done defaults low so it lives exactly one cycle.
  always_comb begin
    state_n       = state;
    md_cnt_n      = md_cnt;
    md_done_n     = 1'b0;
    branch_ev     = 1'b0;
    hz.PCWrite    = 1'b1;
    hz.IFIDWrite  = 1'b1;
    hz.IDEXWrite  = 1'b1;
    hz.IFIDFlush  = 1'b0;
    hz.IDEXFlush  = 1'b0;
    hz.EXMEMFlush = 1'b0;

    if (Reset) begin
      hz.PCWrite    = 1'b0;
      hz.IFIDWrite  = 1'b0;
      hz.IDEXWrite  = 1'b0;
      hz.IFIDFlush  = 1'b1;
      hz.IDEXFlush  = 1'b1;
      hz.EXMEMFlush = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          if (hz.BranchTaken) begin
            hz.IFIDFlush = 1'b1;
            hz.IDEXFlush = 1'b1;
            branch_ev    = 1'b1;
          end else if (hz.IDEX_MulDiv && !md_done) begin
            hz.PCWrite    = 1'b0;
            hz.IFIDWrite  = 1'b0;
            hz.IDEXWrite  = 1'b0;
            hz.EXMEMFlush = 1'b1;
            md_cnt_n      = MD_LOAD;
            if (MD_LOAD != '0) state_n   = MD_WAIT;
            else               md_done_n = 1'b1;
          end else if (load_use) begin
            hz.PCWrite   = 1'b0;
            hz.IFIDWrite = 1'b0;
            hz.IDEXFlush = 1'b1;
          end
        end
        MD_WAIT: begin
          hz.PCWrite    = 1'b0;
          hz.IFIDWrite  = 1'b0;
          hz.IDEXWrite  = 1'b0;
          hz.EXMEMFlush = 1'b1;
          if (md_cnt == CNT_W'(1)) begin
            state_n   = RUN;
            md_done_n = 1'b1;
          end else begin
            md_cnt_n = md_cnt - CNT_W'(1);
          end
        end
        default: state_n = RUN;
      endcase
    end
  end

  // Saturating performance counters.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!hz.PCWrite && (stall_cnt != '1)) stall_cnt <= stall_cnt + PERF_W'(1);
      if (branch_ev && (flush_cnt != '1))   flush_cnt <= flush_cnt + PERF_W'(1);
    end
  end

  assign hz.StallCycles = stall_cnt;
  assign hz.FlushCount  = flush_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: directed vectors push expected controls/counters, a negedge monitor checks.
module tb_hazard_unit;

  localparam logic [5:0] C_DEF = 6'b111_000;  // {PCWrite,IFIDWrite,IDEXWrite,IFIDFlush,IDEXFlush,EXMEMFlush}
  localparam logic [5:0] C_RST = 6'b000_111;
  localparam logic [5:0] C_LU  = 6'b001_010;
  localparam logic [5:0] C_BR  = 6'b111_110;
  localparam logic [5:0] C_MD  = 6'b000_001;

  typedef struct packed {
    logic        sel2;
    logic [5:0]  ctrl;
    logic [31:0] stall;
    logic [31:0] flush;
    logic [15:0] step;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset;
  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   step = 0;

  hazard_unit_if hz4 ();
  hazard_unit_if hz2 ();

  hazard_unit #(.MULDIV_CYCLES(4)) u_dut4 (.Clk(Clk), .Reset(Reset), .hz(hz4.slave));
  hazard_unit #(.MULDIV_CYCLES(2)) u_dut2 (.Clk(Clk), .Reset(Reset), .hz(hz2.slave));

  always #5 Clk = ~Clk;

  task automatic set4(input logic mr, input logic [4:0] wr, input logic [4:0] rs, input logic urs,
                      input logic [4:0] rt, input logic urt, input logic md, input logic br);
    hz4.IDEX_MemRead  = mr;
    hz4.IDEX_WriteReg = wr;
    hz4.ID_Rs         = rs;
    hz4.ID_UsesRs     = urs;
    hz4.ID_Rt         = rt;
    hz4.ID_UsesRt     = urt;
    hz4.IDEX_MulDiv   = md;
    hz4.BranchTaken   = br;
  endtask

  task automatic idle4();
    set4(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Queue the expectation for the current cycle, then advance one clock.
  task automatic cyc(input logic [5:0] c, input int unsigned s, input int unsigned f, input logic u2);
    exp_t e;
    e.sel2  = u2;
    e.ctrl  = c;
    e.stall = 32'(s);
    e.flush = 32'(f);
    e.step  = 16'(step);
    sb.push_back(e);
    step++;
    @(posedge Clk);
    #1;
  endtask

  always @(negedge Clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      logic [5:0]  a_ctrl;
      logic [31:0] a_stall, a_flush;
      e = sb.pop_front();
      if (e.sel2) begin
        a_ctrl  = {hz2.PCWrite, hz2.IFIDWrite, hz2.IDEXWrite, hz2.IFIDFlush, hz2.IDEXFlush, hz2.EXMEMFlush};
        a_stall = hz2.StallCycles;
        a_flush = hz2.FlushCount;
      end else begin
        a_ctrl  = {hz4.PCWrite, hz4.IFIDWrite, hz4.IDEXWrite, hz4.IFIDFlush, hz4.IDEXFlush, hz4.EXMEMFlush};
        a_stall = hz4.StallCycles;
        a_flush = hz4.FlushCount;
      end
      checks++;
      if (a_ctrl !== e.ctrl) begin
        failures++;
        $display("FAIL ctrl step=%0d dut2=%0b got=%b want=%b", e.step, e.sel2, a_ctrl, e.ctrl);
      end
      checks++;
      if ({a_stall, a_flush} !== {e.stall, e.flush}) begin
        failures++;
        $display("FAIL counters step=%0d dut2=%0b got stall=%0d flush=%0d want stall=%0d flush=%0d",
                 e.step, e.sel2, a_stall, a_flush, e.stall, e.flush);
      end
    end
  end

  initial begin
    Reset = 1'b1;
    idle4();
    hz2.IDEX_MemRead = 1'b0; hz2.IDEX_WriteReg = 5'd0; hz2.ID_Rs = 5'd0; hz2.ID_UsesRs = 1'b0;
    hz2.ID_Rt = 5'd0; hz2.ID_UsesRt = 1'b0; hz2.IDEX_MulDiv = 1'b0; hz2.BranchTaken = 1'b0;
    @(posedge Clk); #1;

    // Reset held, then released with idle inputs
    cyc(C_RST, 0, 0, 1'b0);
    cyc(C_RST, 0, 0, 1'b0);
    Reset = 1'b0;
    cyc(C_DEF, 0, 0, 1'b0);

    // Load-use on Rs, then non-hazard variants, then load-use on Rt
    set4(1'b1, 5'd8, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0); cyc(C_LU, 0, 0, 1'b0);
    idle4();                                               cyc(C_DEF, 1, 0, 1'b0);
    set4(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0); cyc(C_DEF, 1, 0, 1'b0);
    set4(1'b1, 5'd8, 5'd8, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); cyc(C_DEF, 1, 0, 1'b0);
    set4(1'b1, 5'd9, 5'd3, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0); cyc(C_LU, 1, 0, 1'b0);
    idle4();                                               cyc(C_DEF, 2, 0, 1'b0);

    // Branch alone, then branch beating a simultaneous load-use
    set4(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1); cyc(C_BR, 2, 0, 1'b0);
    idle4();                                               cyc(C_DEF, 2, 1, 1'b0);
    set4(1'b1, 5'd8, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1); cyc(C_BR, 2, 1, 1'b0);
    idle4();                                               cyc(C_DEF, 2, 2, 1'b0);

    // Single mul/div; branch and load-use during MD_WAIT are ignored
    set4(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); cyc(C_MD, 2, 2, 1'b0);
    set4(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1); cyc(C_MD, 3, 2, 1'b0);
    set4(1'b1, 5'd8, 5'd8, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0); cyc(C_MD, 4, 2, 1'b0);
    set4(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); cyc(C_DEF, 5, 2, 1'b0);
    idle4();                                               cyc(C_DEF, 5, 2, 1'b0);

    // Back-to-back mul/div with IDEX_MulDiv held high throughout
    set4(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    cyc(C_MD, 5, 2, 1'b0);  cyc(C_MD, 6, 2, 1'b0);  cyc(C_MD, 7, 2, 1'b0);  cyc(C_DEF, 8, 2, 1'b0);
    cyc(C_MD, 8, 2, 1'b0);  cyc(C_MD, 9, 2, 1'b0);  cyc(C_MD, 10, 2, 1'b0); cyc(C_DEF, 11, 2, 1'b0);
    idle4();                cyc(C_DEF, 11, 2, 1'b0);

    // Reset during the second MD_WAIT cycle aborts the sequence
    set4(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    cyc(C_MD, 11, 2, 1'b0);
    cyc(C_MD, 12, 2, 1'b0);
    Reset = 1'b1;           cyc(C_RST, 13, 2, 1'b0);
    Reset = 1'b0; idle4();  cyc(C_DEF, 0, 0, 1'b0);
    set4(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    cyc(C_MD, 0, 0, 1'b0);  cyc(C_MD, 1, 0, 1'b0);  cyc(C_MD, 2, 0, 1'b0);  cyc(C_DEF, 3, 0, 1'b0);
    idle4();                cyc(C_DEF, 3, 0, 1'b0);

    // MULDIV_CYCLES=2: one stall cycle, release, then back-to-back
    hz2.IDEX_MulDiv = 1'b1; cyc(C_MD, 0, 0, 1'b1);  cyc(C_DEF, 1, 0, 1'b1);
    hz2.IDEX_MulDiv = 1'b0; cyc(C_DEF, 1, 0, 1'b1);
    hz2.IDEX_MulDiv = 1'b1;
    cyc(C_MD, 1, 0, 1'b1);  cyc(C_DEF, 2, 0, 1'b1); cyc(C_MD, 2, 0, 1'b1);  cyc(C_DEF, 3, 0, 1'b1);
    hz2.IDEX_MulDiv = 1'b0; cyc(C_DEF, 3, 0, 1'b1);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge Clk);
    #1;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
